// File: rtl/hevc_interp_pkg.sv
// Shared constants, coefficient table and phase enumeration for the HEVC luma interpolators.
package hevc_interp_pkg;

  typedef enum logic [1:0] {
    FRAC_INT  = 2'd0,
    FRAC_QTR  = 2'd1,
    FRAC_HALF = 2'd2,
    FRAC_3QTR = 2'd3
  } frac_e;

  localparam int NUM_TAPS  = 8;
  localparam int ROUND_OFS = 32;
  localparam int SHIFT     = 6;

  localparam logic signed [6:0] COEF_TABLE [3][8] = '{
    '{-7'sd1, 7'sd4, -7'sd10, 7'sd58, 7'sd17, -7'sd5, 7'sd1, 7'sd0},
    '{-7'sd1, 7'sd4, -7'sd11, 7'sd40, 7'sd40, -7'sd11, 7'sd4, -7'sd1},
    '{7'sd0, 7'sd1, -7'sd5, 7'sd17, 7'sd58, -7'sd10, 7'sd4, -7'sd1}
  };

  // The integer phase is a unit impulse of weight 64 on tap 3, so it rounds back to tap 3 exactly.
  function automatic logic signed [7:0] tap_coef(frac_e frac, logic [2:0] tap);
    logic signed [6:0] c;
    c = '0;
    case (frac)
      FRAC_QTR:  c = COEF_TABLE[0][tap];
      FRAC_HALF: c = COEF_TABLE[1][tap];
      FRAC_3QTR: c = COEF_TABLE[2][tap];
      default:   c = '0;
    endcase
    if (frac == FRAC_INT) return (tap == 3'd3) ? 8'sd64 : 8'sd0;
    return {c[6], c};
  endfunction

endpackage

// File: rtl/hevc_clip.sv
// Clamps a signed filter result to the pixel range and flags when clamping occurred.
module hevc_clip #(
  parameter int BIT_DEPTH = 8,
  parameter int IN_W      = BIT_DEPTH + 12
) (
  input  logic signed [IN_W-1:0]      value,
  output logic        [BIT_DEPTH-1:0] pixel,
  output logic                        sat
);

  localparam logic signed [IN_W-1:0] MAX_VAL = IN_W'((1 << BIT_DEPTH) - 1);

  always_comb begin
    pixel = value[BIT_DEPTH-1:0];
    sat   = 1'b0;
    if (value[IN_W-1]) begin
      pixel = '0;
      sat   = 1'b1;
    end else if (value > MAX_VAL) begin
      pixel = '1;
      sat   = 1'b1;
    end
  end

endmodule

// File: rtl/hevc_luma_interp_fir.sv
// 8-tap HEVC luma fractional interpolator, 3-stage pipeline with valid/ready flow control.
// Optional saturation counter (sat_cnt_clr/sat_cnt) enabled by defining HEVC_FIR_SAT_COUNT_EN.
module hevc_luma_interp_fir
  import hevc_interp_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int TAG_W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef HEVC_FIR_SAT_COUNT_EN
  input  logic                     sat_cnt_clr,
  output logic [15:0]              sat_cnt,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*BIT_DEPTH-1:0]   in_pixels,
  input  logic [1:0]               in_frac,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_DEPTH-1:0]     out_pixel,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_sat
);

  localparam int PROD_W = BIT_DEPTH + 9;
  localparam int SUM_W  = BIT_DEPTH + 12;

  logic                     advance;
  logic signed [PROD_W-1:0] prod_next [NUM_TAPS];
  logic signed [PROD_W-1:0] prod1     [NUM_TAPS];
  logic                     valid1, valid2;
  logic [TAG_W-1:0]         tag1, tag2;
  logic signed [SUM_W-1:0]  sum1, rnd_next, rnd2;
  logic [BIT_DEPTH-1:0]     clip_pixel;
  logic                     clip_sat;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_next[k] = PROD_W'(tap_coef(frac_e'(in_frac), 3'(k)))
                   * PROD_W'(signed'({1'b0, in_pixels[k*BIT_DEPTH +: BIT_DEPTH]}));
    end
  end

  always_comb begin
    sum1 = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      sum1 = sum1 + SUM_W'(prod1[k]);
    end
    rnd_next = (sum1 + SUM_W'(ROUND_OFS)) >>> SHIFT;
  end

  hevc_clip #(
    .BIT_DEPTH(BIT_DEPTH),
    .IN_W     (SUM_W)
  ) u_clip (
    .value(rnd2),
    .pixel(clip_pixel),
    .sat  (clip_sat)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid1 <= 1'b0;
      valid2 <= 1'b0;
      out_valid <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) prod1[k] <= '0;
      tag1 <= '0;
      tag2 <= '0;
      rnd2 <= '0;
      out_pixel <= '0;
      out_tag <= '0;
      out_sat <= 1'b0;
    end else if (advance) begin
      valid1 <= in_valid;
      for (int k = 0; k < NUM_TAPS; k++) prod1[k] <= prod_next[k];
      tag1 <= in_tag;
      valid2 <= valid1;
      rnd2 <= rnd_next;
      tag2 <= tag1;
      out_valid <= valid2;
      out_pixel <= clip_pixel;
      out_tag <= tag2;
      out_sat <= clip_sat;
    end
  end

`ifdef HEVC_FIR_SAT_COUNT_EN
  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hevc_luma_interp_fir.sv
// Self-checking bench for hevc_luma_interp_fir: directed cases plus randomized traffic against a reference model.
module tb_hevc_luma_interp_fir;

  localparam int BD    = 8;
  localparam int TAG_W = 8;
  localparam int PMAX  = (1 << BD) - 1;
  localparam int COEF [3][8] = '{
    '{-1, 4, -10, 58, 17, -5, 1, 0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{0, 1, -5, 17, 58, -10, 4, -1}
  };

  typedef struct {
    logic [BD-1:0]    pix;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic              clock, reset;
  logic              in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [8*BD-1:0]   in_pixels;
  logic [1:0]        in_frac;
  logic [TAG_W-1:0]  in_tag, out_tag;
  logic [BD-1:0]     out_pixel;
`ifdef HEVC_FIR_SAT_COUNT_EN
  logic              sat_cnt_clr;
  logic [15:0]       sat_cnt;
  int                sat_model;
`endif

  int   n_chk, n_err, n_out;
  exp_t exp_q [$];

  hevc_luma_interp_fir #(.BIT_DEPTH(BD), .TAG_W(TAG_W)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef HEVC_FIR_SAT_COUNT_EN
    .sat_cnt_clr(sat_cnt_clr),
    .sat_cnt    (sat_cnt),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixels  (in_pixels),
    .in_frac    (in_frac),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_tag    (out_tag),
    .out_sat    (out_sat)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer convolution, round, clamp; frac 0 is a straight copy of tap 3.
  function automatic exp_t refModel(logic [8*BD-1:0] px, logic [1:0] f, logic [TAG_W-1:0] t);
    exp_t e;
    int   sum, r, fi;
    e.tag = t;
    fi = int'(f);
    if (fi == 0) begin
      e.pix = px[3*BD +: BD];
      e.sat = 1'b0;
      return e;
    end
    sum = 0;
    for (int k = 0; k < 8; k++) sum += COEF[fi-1][k] * int'(px[k*BD +: BD]);
    r = (sum + 32) >>> 6;
    if (r < 0) begin
      e.pix = '0; e.sat = 1'b1;
    end else if (r > PMAX) begin
      e.pix = BD'(PMAX); e.sat = 1'b1;
    end else begin
      e.pix = BD'(r); e.sat = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [8*BD-1:0] randPixels();
    logic [8*BD-1:0] p;
    for (int k = 0; k < 8; k++) p[k*BD +: BD] = BD'($urandom);
    return p;
  endfunction

  task automatic applyStimulus(input logic v, input logic [8*BD-1:0] px, input logic [1:0] f, input logic [TAG_W-1:0] t);
    in_valid  = v;
    in_pixels = px;
    in_frac   = f;
    in_tag    = t;
  endtask

  // One clock: scoreboard the output transfer, record accepted inputs, verify holds during stalls.
  task automatic cycle(output bit acc);
    bit               xfer, hold;
    logic [BD-1:0]    hp;
    logic [TAG_W-1:0] ht;
    logic             hs;
    exp_t             e;
    #1;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    hold = out_valid && !out_ready;
    hp = out_pixel; ht = out_tag; hs = out_sat;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pixel", 32'(out_pixel), 32'(e.pix));
        checkOutput("tag", 32'(out_tag), 32'(e.tag));
        checkOutput("sat", 32'(out_sat), 32'(e.sat));
        n_out++;
`ifdef HEVC_FIR_SAT_COUNT_EN
        if (e.sat && sat_model < 65535) sat_model++;
`endif
      end
    end
`ifdef HEVC_FIR_SAT_COUNT_EN
    if (sat_cnt_clr) sat_model = 0;
`endif
    if (acc) exp_q.push_back(refModel(in_pixels, in_frac, in_tag));
    @(posedge clock);
    #1;
    if (hold) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_pixel", 32'(out_pixel), 32'(hp));
      checkOutput("hold_tag", 32'(out_tag), 32'(ht));
      checkOutput("hold_sat", 32'(out_sat), 32'(hs));
    end
`ifdef HEVC_FIR_SAT_COUNT_EN
    checkOutput("sat_cnt_model", 32'(sat_cnt), 32'(sat_model));
`endif
  endtask

  task automatic drain();
    bit acc;
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while ((exp_q.size() > 0 || out_valid) && budget < 30) begin
      cycle(acc);
      budget++;
    end
    checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Single sample on an empty pipe: checks latency and the literal expected output.
  task automatic sendOne(input string name, input logic [8*BD-1:0] px, input logic [1:0] f,
                         input logic [TAG_W-1:0] t, input logic [BD-1:0] exp_pix, input logic exp_sat);
    bit acc;
    int lat;
    applyStimulus(1'b1, px, f, t);
    out_ready = 1'b1;
    cycle(acc);
    checkOutput({name, "_accept"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      cycle(acc);
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'd3);
    checkOutput({name, "_pixel"}, 32'(out_pixel), 32'(exp_pix));
    checkOutput({name, "_sat"}, 32'(out_sat), 32'(exp_sat));
    checkOutput({name, "_tag"}, 32'(out_tag), 32'(t));
    cycle(acc);
  endtask

  initial begin
    bit acc, pend;
    int idx, cyc, start;
    logic [8*BD-1:0] px_s [10];
    logic [1:0]      fr_s [10];

    n_chk = 0; n_err = 0; n_out = 0;
    reset = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, 2'd0, '0);
`ifdef HEVC_FIR_SAT_COUNT_EN
    sat_cnt_clr = 1'b0;
    sat_model = 0;
`endif
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_pixel", 32'(out_pixel), 32'd0);
    checkOutput("reset_out_tag", 32'(out_tag), 32'd0);
    checkOutput("reset_out_sat", 32'(out_sat), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef HEVC_FIR_SAT_COUNT_EN
    checkOutput("reset_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    reset = 1'b0;

    sendOne("flat100", {8{8'd100}}, 2'd2, 8'hA1, 8'd100, 1'b0);
    sendOne("ramp_q", {8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0}, 2'd1, 8'hA2, 8'd32, 1'b0);
    sendOne("ramp_int", {8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0}, 2'd0, 8'hA3, 8'd30, 1'b0);
    sendOne("clamp_hi", {8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0}, 2'd2, 8'hA4, 8'd255, 1'b1);
    sendOne("clamp_lo", {8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255}, 2'd2, 8'hA5, 8'd0, 1'b1);

    // Ten tagged samples with a five-cycle downstream stall in the middle.
    for (int i = 0; i < 10; i++) begin
      px_s[i] = randPixels();
      fr_s[i] = 2'($urandom_range(0, 3));
    end
    start = n_out;
    idx = 0;
    cyc = 0;
    while ((idx < 10 || exp_q.size() > 0) && cyc < 100) begin
      if (idx < 10) applyStimulus(1'b1, px_s[idx], fr_s[idx], TAG_W'(idx));
      else in_valid = 1'b0;
      out_ready = !(cyc >= 5 && cyc < 10);
      #1;
      if (!out_ready && out_valid) checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_ready) checkOutput("flow_in_ready", 32'(in_ready), 32'd1);
      cycle(acc);
      if (acc && idx < 10) idx++;
      cyc++;
    end
    checkOutput("stall_count", 32'(n_out - start), 32'd10);
    drain();

    // Randomized traffic with random backpressure and bubbles.
    pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          applyStimulus(1'b1, randPixels(), 2'($urandom_range(0, 3)), TAG_W'($urandom));
          pend = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) pend = 1'b0;
    end
    drain();

    // Reset with three samples in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, randPixels(), 2'($urandom_range(1, 3)), TAG_W'(8'hC0 + i));
      cycle(acc);
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_pixel", 32'(out_pixel), 32'd0);
    checkOutput("midrst_out_tag", 32'(out_tag), 32'd0);
    exp_q.delete();
`ifdef HEVC_FIR_SAT_COUNT_EN
    sat_model = 0;
    checkOutput("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(acc);
      checkOutput("no_stale", 32'(out_valid), 32'd0);
    end
    sendOne("post_rst", {8{8'd100}}, 2'd2, 8'hB7, 8'd100, 1'b0);

`ifdef HEVC_FIR_SAT_COUNT_EN
    sat_cnt_clr = 1'b1;
    cycle(acc);
    sat_cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++)
      sendOne("cnt_hi", {8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0}, 2'd2, TAG_W'(i), 8'd255, 1'b1);
    checkOutput("sat_cnt_4", 32'(sat_cnt), 32'd4);
    applyStimulus(1'b1, {8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0}, 2'd2, 8'hD0);
    cycle(acc);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      cycle(acc);
      cyc++;
    end
    checkOutput("clr_wait", 32'(out_valid), 32'd1);
    sat_cnt_clr = 1'b1;
    cycle(acc);
    sat_cnt_clr = 1'b0;
    checkOutput("sat_cnt_clr_wins", 32'(sat_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hevc_luma_interp_fir.md
HEVC_LUMA_INTERP_FIR -- requirements
Module: hevc_luma_interp_fir

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8: pixel bit depth, legal range 8..12.
REQ-002 SHALL have parameter TAG_W, default 8: width of the sideband tag carried alongside each sample.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input sample is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the input sample this cycle.
REQ-007 SHALL have port in_pixels, input, 8*BIT_DEPTH bits: tap k occupies bits [k*BIT_DEPTH +: BIT_DEPTH]; tap 0 is the leftmost; tap 3 is the integer position.
REQ-008 SHALL have port in_frac, input, 2 bits: phase select; 0 = integer, 1 = quarter, 2 = half, 3 = three-quarter.
REQ-009 SHALL have port in_tag, input, TAG_W bits: sideband tag, passed through unmodified.
REQ-010 SHALL have port out_valid, output, 1 bit: the output sample is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the output sample.
REQ-012 SHALL have port out_pixel, output, BIT_DEPTH bits: the interpolated sample.
REQ-013 SHALL have port out_tag, output, TAG_W bits: the tag of the sample on out_pixel.
REQ-014 SHALL have port out_sat, output, 1 bit: out_pixel was clamped high or low.
REQ-015 SHALL have port sat_cnt_clr, input, 1 bit, and port sat_cnt, output, 16 bits; both exist only under the macro in REQ-031.

Function
REQ-016 SHALL use these coefficients, listed tap 0..7:
- frac1 = {-1,4,-10,58,17,-5,1,0}
- frac2 = {-1,4,-11,40,40,-11,4,-1}
- frac3 = {0,1,-5,17,58,-10,4,-1}
REQ-017 SHALL compute sum = Σ coef[k]*unsigned(tap k) in signed arithmetic at least BIT_DEPTH+9 bits wide, with no intermediate truncation.
REQ-018 SHALL form result = (sum + 32) arithmetic-shifted right by 6.
REQ-019 SHALL clamp the result to [0, 2^BIT_DEPTH-1] and assert out_sat when the clamp is applied.
REQ-020 SHALL, for frac 0, output tap 3 unchanged with out_sat = 0.
REQ-021 SHALL be a 3-stage pipeline:
- S1 registers the eight products;
- S2 registers the rounded sum;
- S3 registers the clamped out_pixel, out_tag and out_sat.
REQ-022 SHALL have a latency of exactly 3 cycles from the accepting edge to out_valid when out_ready is held high.
REQ-023 SHALL sustain a throughput of one sample per cycle while out_ready is high.
REQ-024 SHALL define advance = out_ready | ~out_valid; all stages and their valid bits SHALL shift only when advance = 1.
REQ-025 SHALL drive in_ready = advance; a transfer occurs when in_valid & in_ready.
REQ-026 SHALL hold out_pixel, out_tag, out_sat and out_valid stable while out_valid & ~out_ready.
REQ-027 SHALL never drop, duplicate or reorder samples.
REQ-028 SHALL keep in_frac and in_tag associated with their own sample through every stage.

Reset
REQ-029 SHALL, on reset assertion, clear all stage valid bits immediately (asynchronously) and drive out_valid = 0, out_pixel = 0, out_tag = 0, out_sat = 0 and sat_cnt = 0.
REQ-030 SHALL discard in-flight samples on reset mid-operation; the first sample accepted after reset release emerges 3 cycles later.

Configuration
REQ-031 SHALL include, when HEVC_FIR_SAT_COUNT_EN is defined, the sat_cnt_clr and sat_cnt ports and a 16-bit counter that:
- increments on each output transfer (out_valid & out_ready) with out_sat = 1;
- saturates at 0xFFFF;
- clears synchronously on sat_cnt_clr;
- clears rather than increments when clear and increment coincide.
REQ-032 SHALL, when HEVC_FIR_SAT_COUNT_EN is not defined, have neither the ports nor the counter logic; all other behaviour is identical.

Structure
REQ-033 SHALL take the coefficient table (3 phases x 8 taps, signed 7-bit), the constants ROUND_OFS = 32 and SHIFT = 6, and the frac enumeration from shared package hevc_interp_pkg.
REQ-034 SHALL place the clamp-and-flag logic in one sub-module, hevc_clip, parametrised by BIT_DEPTH and reused by the 2-D interpolator.

Verification
REQ-035 SHALL cover: all taps = 100, frac2, out_ready = 1 -> out_pixel = 100, out_sat = 0, out_valid exactly 3 cycles after acceptance.
REQ-036 SHALL cover: taps = 10*k (k = 0..7), frac1 -> sum = 2070, out_pixel = 32; frac0 -> out_pixel = 30.
REQ-037 SHALL cover: taps {0,0,0,255,255,0,0,0}, frac2 -> out_pixel = 255, out_sat = 1; taps {255,255,255,0,0,255,255,255}, frac2 -> out_pixel = 0, out_sat = 1.
REQ-038 SHALL cover: stream of 10 tagged samples with out_ready low for 5 cycles mid-stream -> in_ready low while stalled, output held stable, all 10 tags exit in order without loss.
REQ-039 SHALL cover: reset asserted with 3 samples in flight -> out_valid = 0 immediately, no stale sample emerges after release.
REQ-040 SHALL cover, with HEVC_FIR_SAT_COUNT_EN: 4 clamped outputs -> sat_cnt = 4; sat_cnt_clr coincident with a clamped transfer -> sat_cnt = 0.
